// File: rtl/random_burst_ctrl.sv
// Burst sequencer for the LFSR random pulser: release, dead-time qualify, count, end.
// Optional RANDOM_BURST_DEADTIME_EN enables the per-pulse dead-time counter.
module random_burst_ctrl #(
   parameter int CNT_W  = 16,
   parameter int DEAD_W = 8,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        cfg_thresh,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic [31:0]       cfg_window,
   input  logic [DEAD_W-1:0] cfg_dead,
   input  logic              pulse_in,
   output logic              pulser_reset,
   output logic [7:0]        pulser_thresh,
   output logic              pulse_out,
   output logic              busy,
   output logic              done,
   output logic              timed_out,
   output logic [CNT_W-1:0]  pulse_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   state_t r_state;
   state_t w_next;

   logic [SW-1:0]    r_settle;
   logic [7:0]       r_thresh;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_window;
   logic [31:0]      r_win_cnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pulse_out;
   logic             r_timed_out;

   logic             w_start_ok;
   logic             w_run_live;
   logic             w_accept;
   logic             w_cnt_hit;
   logic             w_win_hit;
   logic             w_dead_ok;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [31:0]      w_win_inc;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_win_inc = r_win_cnt + 32'd1;

`ifdef RANDOM_BURST_DEADTIME_EN
   logic [DEAD_W-1:0] r_dead_cfg;
   logic [DEAD_W-1:0] r_dead;

   assign w_dead_ok = (r_dead == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dead_cfg <= '0;
         r_dead     <= '0;
      end else if (w_start_ok) begin
         r_dead_cfg <= cfg_dead;
         r_dead     <= '0;
      end else if (w_run_live) begin
         if (w_accept)
            r_dead <= r_dead_cfg;
         else if (r_dead != '0)
            r_dead <= r_dead - DEAD_W'(1);
      end
   end
`else
   logic w_unused_dead;

   assign w_unused_dead = ^cfg_dead;
   assign w_dead_ok     = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start_ok = 1'b0;
      w_run_live = 1'b0;
      w_accept   = 1'b0;
      w_cnt_hit  = 1'b0;
      w_win_hit  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_start_ok = 1'b1;
               w_next     = S_ARM;
            end
         end
         S_ARM: begin
            if (abort)
               w_next = S_IDLE;
            else if (r_settle == SETTLE_LAST)
               w_next = S_RUN;
         end
         S_RUN: begin
            if (abort) begin
               w_next = S_IDLE;
            end else begin
               w_run_live = 1'b1;
               w_accept   = pulse_in && w_dead_ok;
               w_cnt_hit  = w_accept && (r_count != '0)
                            && (w_cnt_inc == r_count);
               w_win_hit  = (r_window != '0) && (w_win_inc == r_window);
               if (w_cnt_hit || w_win_hit)
                  w_next = S_DONE;
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_settle    <= '0;
         r_thresh    <= '0;
         r_count     <= '0;
         r_window    <= '0;
         r_win_cnt   <= '0;
         r_cnt       <= '0;
         r_pulse_out <= 1'b0;
         r_timed_out <= 1'b0;
      end else begin
         r_pulse_out <= w_accept;
         if (w_start_ok) begin
            r_settle    <= '0;
            r_thresh    <= cfg_thresh;
            r_count     <= cfg_count;
            r_window    <= cfg_window;
            r_win_cnt   <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
         end
         if (r_state == S_ARM)
            r_settle <= r_settle + SW'(1);
         if (w_run_live) begin
            r_win_cnt <= w_win_inc;
            // Saturate so an unlimited burst never wraps to zero.
            if (w_accept && (r_cnt != '1))
               r_cnt <= w_cnt_inc;
            if (w_win_hit && !w_cnt_hit)
               r_timed_out <= 1'b1;
         end
      end
   end

   assign pulser_reset  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign busy          = (r_state == S_ARM) || (r_state == S_RUN);
   assign done          = (r_state == S_DONE);
   assign pulser_thresh = r_thresh;
   assign pulse_out     = r_pulse_out;
   assign timed_out     = r_timed_out;
   assign pulse_cnt     = r_cnt;

endmodule

// File: tb/tb_random_burst_ctrl.sv
// Directed bench for random_burst_ctrl with hand-computed cycle expectations.
// Start is sampled at edge 1; cycle k is the interval after edge k.
module tb_random_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  cfg_thresh = '0;
   logic [15:0] cfg_count = '0;
   logic [31:0] cfg_window = '0;
   logic [7:0]  cfg_dead = '0;
   logic        pulse_in = 1'b0;
   logic        pulser_reset;
   logic [7:0]  pulser_thresh;
   logic        pulse_out;
   logic        busy;
   logic        done;
   logic        timed_out;
   logic [15:0] pulse_cnt;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [255:0] pin_pat;
   int          pc [16];
   int          np;
   int          dc;
   logic        bd;
   logic        seen_done;

   random_burst_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_thresh    (cfg_thresh),
      .cfg_count     (cfg_count),
      .cfg_window    (cfg_window),
      .cfg_dead      (cfg_dead),
      .pulse_in      (pulse_in),
      .pulser_reset  (pulser_reset),
      .pulser_thresh (pulser_thresh),
      .pulse_out     (pulse_out),
      .busy          (busy),
      .done          (done),
      .timed_out     (timed_out),
      .pulse_cnt     (pulse_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [15:0] cnt,
                           input logic [7:0] thr, input logic to);
      chk({tag, "_prst"}, pulser_reset, 1);
      chk({tag, "_thr"}, pulser_thresh, thr);
      chk({tag, "_pout"}, pulse_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_to"}, timed_out, to);
      chk({tag, "_cnt"}, pulse_cnt, cnt);
   endtask

   task automatic set_cfg(input logic [7:0] th, input logic [15:0] c,
                          input logic [31:0] w, input logic [7:0] d);
      cfg_thresh = th;
      cfg_count  = c;
      cfg_window = w;
      cfg_dead   = d;
   endtask

   task automatic run_burst(input int max_cyc);
      np = 0;
      dc = -1;
      bd = 1'b1;
      start = 1'b1;
      pulse_in = pin_pat[0];
      for (int k = 1; k <= max_cyc; k++) begin
         tick();
         start = 1'b0;
         pulse_in = pin_pat[k];
         if (k == 1) begin
            chk("busy_t1", busy, 1);
            chk("prst_t1", pulser_reset, 0);
            chk("thresh_t1", pulser_thresh, cfg_thresh);
         end
         if (pulse_out) begin
            if (np < 16) pc[np] = k;
            np++;
         end
         if (done) begin
            dc = k;
            bd = busy;
            break;
         end
      end
      pulse_in = 1'b0;
   endtask

   initial begin
      pin_pat = '0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_prst", pulser_reset, 1);
      end
      chk_idle("rst", 16'd0, 8'h00, 1'b0);

      // Count-terminated burst, pulse_in always high, no dead time
      set_cfg(8'h40, 16'd5, 32'd0, 8'd0);
      pin_pat = '1;
      run_burst(40);
      chk("c5_npulse", np, 5);
      chk("c5_first", pc[0], 6);
      chk("c5_fifth", pc[4], 10);
      chk("c5_done", dc, 10);
      chk("c5_busy_at_done", bd, 0);
      chk("c5_cnt", pulse_cnt, 5);
      chk("c5_to", timed_out, 0);
      tick();
      chk_idle("c5_after", 16'd5, 8'h40, 1'b0);

      // Dead time 3 with pulse_in held high
      set_cfg(8'h11, 16'd3, 32'd0, 8'd3);
      pin_pat = '1;
      run_burst(40);
      chk("dt_npulse", np, 3);
`ifdef RANDOM_BURST_DEADTIME_EN
      chk("dt_gap", pc[1] - pc[0], 4);
      chk("dt_done", dc, 14);
`else
      chk("dt_gap", pc[1] - pc[0], 1);
      chk("dt_done", dc, 8);
`endif
      chk("dt_cnt", pulse_cnt, 3);
      tick();

      // Window expiry with no pulses
      set_cfg(8'h22, 16'd0, 32'd100, 8'd0);
      pin_pat = '0;
      run_burst(150);
      chk("w100_npulse", np, 0);
      chk("w100_done", dc, 105);
      chk("w100_to", timed_out, 1);
      chk("w100_cnt", pulse_cnt, 0);
      tick();
      chk_idle("w100_after", 16'd0, 8'h22, 1'b1);

      // Count reached on the last window cycle: count wins
      set_cfg(8'h33, 16'd3, 32'd10, 8'd0);
      pin_pat = '0;
      pin_pat[5] = 1'b1;
      pin_pat[9] = 1'b1;
      pin_pat[14] = 1'b1;
      run_burst(40);
      chk("tie_npulse", np, 3);
      chk("tie_last", pc[2], 15);
      chk("tie_done", dc, 15);
      chk("tie_to", timed_out, 0);
      chk("tie_cnt", pulse_cnt, 3);
      tick();

      // Window expiry after a few pulses
      set_cfg(8'h44, 16'd0, 32'd10, 8'd0);
      pin_pat = '0;
      pin_pat[6] = 1'b1;
      pin_pat[7] = 1'b1;
      run_burst(40);
      chk("wp_done", dc, 15);
      chk("wp_to", timed_out, 1);
      chk("wp_cnt", pulse_cnt, 2);
      tick();

      // Start and abort together: stay idle, results held
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_idle("sa", 16'd2, 8'h44, 1'b1);
      tick();
      chk("sa_busy2", busy, 0);

      // Abort in RUN after two accepted pulses
      set_cfg(8'h55, 16'd0, 32'd0, 8'd0);
      seen_done = 1'b0;
      start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         start = 1'b0;
         pulse_in = (k == 5 || k == 6);
         if (done) seen_done = 1'b1;
      end
      chk("ab_busy_pre", busy, 1);
      chk("ab_cnt_pre", pulse_cnt, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_prst", pulser_reset, 1);
      chk("ab_cnt", pulse_cnt, 2);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("ab_nodone", seen_done, 0);

      // Reset mid-RUN while a pulse_out is in flight
      set_cfg(8'h66, 16'd0, 32'd0, 8'd0);
      start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         start = 1'b0;
         pulse_in = 1'b1;
      end
      chk("rr_pout_pre", pulse_out, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pulse_in = 1'b0;
      chk_idle("rr", 16'd0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/random_burst_ctrl.md
# random_burst_ctrl

Sequencer for the LFSR random pulse generator. Holds the pulser in reset when idle, releases it on a start request, and qualifies its per-cycle pulse output with a programmable dead time. It counts accepted pulses and ends the burst after a target pulse count or a cycle window. Sits between the control/register interface and the `random` pulser instance, driving that instance's `reset` and `thresh` inputs.

## Interface
- `CNT_W`, 16: width of the pulse-count target and the pulse counter
- `DEAD_W`, 8: width of the dead-time setting
- `SETTLE`, 4: number of ARM cycles after pulser release before pulses are accepted; must be ≥1
- `clk` in 1: single clock; all logic is on the rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle burst request
- `abort` in 1: one-cycle burst cancel
- `cfg_thresh` in 8: threshold, latched on an accepted `start`
- `cfg_count` in CNT_W: target accepted-pulse count; 0 means unlimited
- `cfg_window` in 32: maximum RUN length in cycles; 0 means unlimited
- `cfg_dead` in DEAD_W: dead-time cycles after each accepted pulse
- `pulse_in` in 1: pulser output; each high cycle is one candidate event
- `pulser_reset` out 1: drives the pulser's `reset`
- `pulser_thresh` out 8: drives the pulser's `thresh`
- `pulse_out` out 1: one-cycle strobe per accepted pulse
- `busy` out 1: high in ARM and RUN
- `done` out 1: one-cycle strobe on normal burst end
- `timed_out` out 1: set when the burst ended by window expiry
- `pulse_cnt` out CNT_W: accepted pulses in the current or last burst

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE: `pulser_reset` is 1. A `start` moves to ARM. Entering ARM does the following:
  - latches `cfg_thresh`, `cfg_count`, `cfg_window`, `cfg_dead`
  - clears `pulse_cnt`, `timed_out`, the window counter and the dead counter
- ARM: `pulser_reset` is 0. Stays SETTLE cycles, then moves to RUN. `pulse_in` is ignored.
- RUN: `pulser_reset` is 0.
  - Window counter increments every cycle.
  - A candidate is accepted when `pulse_in`=1 and dead counter = 0.
  - On acceptance: dead counter loads `cfg_dead`, `pulse_cnt` increments, `pulse_out` pulses.
  - A nonzero dead counter decrements each cycle.
- RUN ends (next state DONE) on either condition:
  - an accepted pulse brings `pulse_cnt` to `cfg_count` (when `cfg_count`≠0)
  - window counter reaches `cfg_window` (when `cfg_window`≠0); this also sets `timed_out`=1
- Simultaneous count reached and window expiry: the pulse is counted, `timed_out`=0.
- DONE: lasts one cycle with `done`=1 and `pulser_reset`=1, then IDLE.
- `pulse_cnt` and `timed_out` hold until the next accepted `start`.
- `abort` in ARM/RUN/DONE: next state IDLE and `pulser_reset`=1; no `done` strobe; `pulse_cnt` holds.
- `start` while in ARM, RUN or DONE is ignored.
- `start` and `abort` in the same cycle: abort wins.
- `pulse_cnt` saturates at all-ones when `cfg_count`=0.
- `pulser_thresh` is driven from the latched threshold and is stable for the whole burst.

## Timing
- Reset values: `pulser_reset`=1, `pulser_thresh`=0, `pulse_out`=0, `busy`=0, `done`=0, `timed_out`=0, `pulse_cnt`=0; state IDLE.
- `reset` mid-burst: all of the above apply on the next edge; any in-flight `pulse_out`/`done` is dropped.
- `start` sampled at cycle t:
  - `busy`=1 and `pulser_reset`=0 at t+1
  - first RUN cycle is t+1+SETTLE
- Acceptance sampled at cycle t: `pulse_out`=1 and `pulse_cnt` updated at t+1.
- Dead time: with `cfg_dead`=D, the earliest next acceptance is at t+D+1. D=0 accepts back-to-back cycles.
- Window: with `cfg_window`=W, RUN lasts exactly W cycles. DONE is at first-RUN+W and `done`=1 in that cycle.
- Count end: the final acceptance is at cycle t; DONE and `done`=1 at t+1, coincident with the final `pulse_out`.
- `busy` falls in the DONE cycle.

## Configuration
- `RANDOM_BURST_DEADTIME_EN` defined:
  - dead-time logic and `cfg_dead` are active as described above
- `RANDOM_BURST_DEADTIME_EN` undefined:
  - dead counter is removed; the `cfg_dead` port remains but is ignored
  - every `pulse_in` high cycle in RUN is accepted

## Test plan
- Reset then idle 20 cycles → all outputs at reset values; `pulser_reset`=1 throughout.
- `cfg_thresh`=8'h40, `cfg_count`=5, `cfg_window`=0, `cfg_dead`=0, `start` → `busy` at t+1, `pulser_thresh`=8'h40; exactly 5 `pulse_out` strobes; `done` coincides with the 5th; `pulse_cnt`=5, `timed_out`=0.
- `pulse_in` held at 1, `cfg_dead`=3 (macro defined) → acceptances every 4th cycle. Same test with the macro undefined → acceptance every cycle.
- `cfg_count`=0, `cfg_window`=100, `pulse_in` forced to 0 → `done` exactly 100 cycles after RUN entry; `timed_out`=1; `pulse_cnt`=0.
- `cfg_count`=3, `cfg_window`=10, `pulse_in` arranged so the 3rd acceptance lands on RUN cycle 10 → `pulse_cnt`=3, `timed_out`=0.
- Start plus abort in the same cycle → stays IDLE. Abort in RUN after 2 pulses → IDLE next cycle, no `done`, `pulse_cnt`=2; `reset` mid-RUN → reset values next cycle.
